div_iter: RTL and testbench

Parametrised iterative radix-2 divider for the pipeline's EX stage, serving DIV/DIVU and any multi-cycle divide path. Replaces the fixed 32-bit divider with a WIDTH-generic unit. Adds abort via `annul_i` or `start_i` drop, a divide-by-zero flag, and a compile-time early-out path. EX holds `start_i` and stalls through `ctrl` until `ready_o`.

---
 rtl/div_iter.sv | 169 ++++++++++++++++
 tb/tb_div_iter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// rtl/div_iter.sv - WIDTH-generic iterative radix-2 restoring divider
//
// One quotient bit per cycle, signed or unsigned. Divide-by-zero is flagged
// rather than trapped, and an operation can be aborted at any time before
// its result is presented.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, an operation whose dividend magnitude is smaller than a
//   non-zero divisor magnitude finishes in one cycle. It gives the same
//   result as the full iteration.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst            asynchronous active-high reset
//   signed_div_i   1 = two's-complement divide, 0 = unsigned
//   opdata1_i      dividend
//   opdata2_i      divisor
//   start_i        request; held high until ready_o is seen
//   annul_i        abort the current operation
//   result_o       {remainder, quotient}, valid while ready_o is high
//   ready_o        result valid
//   busy_o         iterating, or resolving a zero divisor
//   div_by_zero_o  qualifies ready_o when the divisor was zero

module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BY_ZERO, ST_ON, ST_END} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] dvd_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic             a_neg_q;
  logic             b_neg_q;

  // Operand conditioning; only used on the capture edge.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign a_mag = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign b_mag = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // One restoring step. The partial remainder is always below the divisor,
  // so after the shift it is below twice the divisor and a successful trial
  // difference fits back into WIDTH bits.
  logic [WIDTH:0]   shifted, diff;
  logic             step_ok;
  logic [WIDTH-1:0] rem_d, quo_d;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign step_ok = ~diff[WIDTH];
  assign rem_d   = step_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_d   = {dvd_q[WIDTH-2:0], step_ok};

  // Sign fix-up of the finished magnitudes. a_neg_q/b_neg_q already include
  // the signed-mode qualifier. Most-negative / -1 wraps naturally here.
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign quo_fix = (a_neg_q ^ b_neg_q) ? (~dvd_q + 1'b1) : dvd_q;
  assign rem_fix = a_neg_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      a_neg_q       <= 1'b0;
      b_neg_q       <= 1'b0;
      result_o      <= '0;
      ready_o       <= 1'b0;
      busy_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && !annul_i) begin
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            if (opdata2_i == '0) begin
              state_q <= ST_BY_ZERO;
              busy_o  <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            end else if (a_mag < b_mag) begin
              // Quotient is zero and the remainder is the untouched dividend.
              state_q  <= ST_END;
              ready_o  <= 1'b1;
              result_o <= {opdata1_i, {WIDTH{1'b0}}};
`endif
            end else begin
              state_q <= ST_ON;
              busy_o  <= 1'b1;
              cnt_q   <= '0;
              rem_q   <= '0;
              dvd_q   <= a_mag;
              dvs_q   <= b_mag;
            end
          end
        end

        ST_BY_ZERO: begin
          busy_o <= 1'b0;
          if (annul_i || !start_i) begin
            state_q <= ST_IDLE;
          end else begin
            state_q       <= ST_END;
            ready_o       <= 1'b1;
            div_by_zero_o <= 1'b1;
            result_o      <= '0;
          end
        end

        ST_ON: begin
          if (annul_i || !start_i) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
          end else if (cnt_q == CW'(WIDTH)) begin
            state_q  <= ST_END;
            busy_o   <= 1'b0;
            ready_o  <= 1'b1;
            result_o <= {rem_fix, quo_fix};
          end else begin
            rem_q <= rem_d;
            dvd_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_END: begin
          // Hold the result until the requester lets go of start_i.
          if (!start_i) begin
            state_q       <= ST_IDLE;
            ready_o       <= 1'b0;
            div_by_zero_o <= 1'b0;
            result_o      <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed self-checking bench for div_iter

module tb_div_iter;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_EDGE = 0;
  localparam bit EO_BUSY = 1'b0;
`else
  localparam int EO_EDGE = 33;
  localparam bit EO_BUSY = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sdiv;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready, busy, dbz;

  logic [7:0]  op1_8, op2_8;
  logic        start8;
  logic [15:0] result8;
  logic        ready8, busy8, dbz8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .signed_div_i(sdiv),
    .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready), .busy_o(busy), .div_by_zero_o(dbz)
  );

  div_iter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .signed_div_i(1'b0),
    .opdata1_i(op1_8), .opdata2_i(op2_8), .start_i(start8), .annul_i(1'b0),
    .result_o(result8), .ready_o(ready8), .busy_o(busy8), .div_by_zero_o(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle. Edge 0 is the first posedge.
  task automatic run_div(input string tag, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input bit exp_dbz, input int exp_edge, input bit exp_busy);
    int n;
    sdiv  = s;
    op1   = a;
    op2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    op1  = 32'hDEAD_BEEF;
    op2  = 32'h0;
    sdiv = ~s;
    @(negedge clk);
    check({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, ".edge"}, 64'(n), 64'(exp_edge));
    check({tag, ".result"}, result, exp_res);
    check({tag, ".dbz"}, 64'(dbz), 64'(exp_dbz));
    @(posedge clk);
    @(negedge clk);
    check({tag, ".hold"}, {ready, result[62:0]}, {1'b1, exp_res[62:0]});
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".clear"}, {61'd0, ready, dbz, |result}, 64'd0);
  endtask

  initial begin
    int  n;
    bit  saw_ready;
    rst = 1'b1; sdiv = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    op1_8 = '0; op2_8 = '0; start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", {60'd0, ready, busy, dbz, |result}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("u100_7",   1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},               1'b0, 33, 1'b1);
    run_div("s-7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 33, 1'b1);
    run_div("smin_-1",  1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000},         1'b0, 33, 1'b1);
    run_div("s7_-2",    1'b1, 32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},         1'b0, 33, 1'b1);
    run_div("s-7_-2",   1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3},         1'b0, 33, 1'b1);
    run_div("umax_1",   1'b0, 32'hFFFFFFFF, 32'd1,        {32'd0, 32'hFFFFFFFF},         1'b0, 33, 1'b1);
    run_div("u_dz",     1'b0, 32'd123,      32'd0,        64'd0,                         1'b1, 1,  1'b1);
    run_div("s_dz",     1'b1, 32'hFFFFFFFB, 32'd0,        64'd0,                         1'b1, 1,  1'b1);
    run_div("eo5_9",    1'b0, 32'd5,        32'd9,        {32'd5, 32'd0},                1'b0, EO_EDGE, EO_BUSY);
    run_div("eo-3_7",   1'b1, 32'hFFFFFFFD, 32'd7,        {32'hFFFFFFFD, 32'd0},         1'b0, EO_EDGE, EO_BUSY);
    run_div("eo0_5",    1'b0, 32'd0,        32'd5,        64'd0,                         1'b0, EO_EDGE, EO_BUSY);
    run_div("eo_umin",  1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0},         1'b0, EO_EDGE, EO_BUSY);

    // Annul in cycle 10 of 1000 / 3.
    sdiv = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("annul.idle", {62'd0, busy, ready}, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready || result != 64'd0) saw_ready = 1'b1;
    end
    check("annul.noready", 64'(saw_ready), 64'd0);
    run_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 33, 1'b1);

    // Asynchronous reset at cycle 15.
    sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("rst.busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst.async", {60'd0, ready, busy, dbz, |result}, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_div("after_rst", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0, 33, 1'b1);

    // WIDTH=8: 200 / 3.
    op1_8 = 8'd200; op2_8 = 8'd3; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("w8.busy", 64'(busy8), 64'd1);
    n = 0;
    while (!ready8 && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("w8.edge", 64'(n), 64'd9);
    check("w8.result", 64'(result8), 64'({8'd2, 8'd66}));
    check("w8.dbz", 64'(dbz8), 64'd0);
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w8.clear", {62'd0, ready8, |result8}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
